// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding, the iteration-counter width and the prefix-tree cells.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Counter must hold 0 .. WIDTH/STEP inclusive.
  function automatic int unsigned cnt_width(int unsigned width, int unsigned step);
    return $clog2(width / step + 1);
  endfunction

  // Black cell: combines generate and propagate of two adjacent groups; returns {g, p}.
  function automatic logic [1:0] black_cell(logic gi, logic pi, logic gj, logic pj);
    return {gi | (pi & gj), pi & pj};
  endfunction

  // Grey cell: used where the lower group already reaches bit 0, so only generate is needed.
  function automatic logic grey_cell(logic gi, logic pi, logic gj);
    return gi | (pi & gj);
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// N-bit Sklansky parallel-prefix adder, carry-in 0, carry-out dropped.
// The prefix tree runs over bits 0..N-2 only, since the top carry never reaches the sum.
module prefix_adder
  import mult_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] p0;
  logic [N-2:0] g;
  logic [N-2:0] p;
  logic [1:0]   gp;
  int           j;

  always_comb begin
    p0 = a_i ^ b_i;
    g  = a_i[N-2:0] & b_i[N-2:0];
    p  = p0[N-2:0];
    gp = '0;
    j  = 0;
    // In-place update is safe: the partner j always has bit l clear, so it is untouched this level.
    for (int l = 0; (1 << l) < (N - 1); l++) begin
      for (int i = 0; i < N - 1; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          if ((i >> (l + 1)) == 0) begin
            g[i] = grey_cell(g[i], p[i], g[j]);
          end else begin
            gp   = black_cell(g[i], p[i], g[j], p[j]);
            g[i] = gp[1];
            p[i] = gp[0];
          end
        end
      end
    end
    sum_o = p0 ^ {g, 1'b0};
  end

endmodule

// File: rtl/seq_mult_pp.sv
// Multi-cycle shift-add multiplier retiring STEP multiplier bits per cycle,
// with valid/ready handshakes and signed/unsigned operand modes.
module seq_mult_pp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     x_i,
  input  logic [WIDTH-1:0]     y_i,
  input  logic                 is_signed_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   o_o,
  output logic                 busy_o
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned Iters = WIDTH / STEP;
  localparam int unsigned CntW  = cnt_width(WIDTH, STEP);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_mult_pp: WIDTH must be at least 2");
  end
  if (STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_step
    $error("seq_mult_pp: STEP must divide WIDTH and lie in 1..WIDTH");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     xm_q, xm_d;
  logic [WIDTH-1:0]  ym_q, ym_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     o_q, o_d;

  logic [WIDTH-1:0]  x_mag, y_mag;
  logic [PW-1:0]     row, maj;
  logic [PW-1:0]     csa_sum, csa_carry;
  logic [PW-1:0]     acc_sum, neg_sum;
  logic [PW-1:0]     one;
  logic              last_iter;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign x_mag = (is_signed_i && x_i[WIDTH-1]) ? -x_i : x_i;
  assign y_mag = (is_signed_i && y_i[WIDTH-1]) ? -y_i : y_i;

  // xm_q is pre-shifted each iteration, so row k of this cycle is simply xm_q << k.
  always_comb begin
    csa_sum   = acc_q;
    csa_carry = '0;
    row       = '0;
    maj       = '0;
    for (int k = 0; k < STEP; k++) begin
      row       = ym_q[k] ? (xm_q << k) : '0;
      maj       = (csa_sum & csa_carry) | (csa_sum & row) | (csa_carry & row);
      csa_sum   = csa_sum ^ csa_carry ^ row;
      csa_carry = maj << 1;
    end
  end

  assign one = {{(PW - 1){1'b0}}, 1'b1};

  prefix_adder #(
    .N (PW)
  ) u_acc_add (
    .a_i   (csa_sum),
    .b_i   (csa_carry),
    .sum_o (acc_sum)
  );

  prefix_adder #(
    .N (PW)
  ) u_neg_add (
    .a_i   (~acc_sum),
    .b_i   (one),
    .sum_o (neg_sum)
  );

  assign last_iter = (cnt_q == CntW'(Iters - 1));

  always_comb begin
    state_d = state_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          xm_d    = {{WIDTH{1'b0}}, x_mag};
          ym_d    = y_mag;
          neg_d   = is_signed_i & (x_i[WIDTH-1] ^ y_i[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_sum;
        xm_d  = xm_q << STEP;
        ym_d  = ym_q >> STEP;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          o_d     = neg_q ? neg_sum : acc_sum;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      xm_q    <= '0;
      ym_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      xm_q    <= xm_d;
      ym_q    <= ym_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle) && !rst_i;
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign o_o         = o_q;

endmodule
